// File: rtl/imem_responder.sv
// imem_responder: instruction-memory fetch responder with wait states, fault flagging and a load port
// Ports: clk, reset (async, active-high); req_valid/req_ready/req_addr fetch request handshake;
// rsp_valid/rsp_ready/rsp_data/rsp_err response handshake with instruction word and fault flag;
// load_en/load_addr/load_data word-write port for the program image; busy high while not idle.
module imem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT = 4'(LATENCY);
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2;
  logic [1:0]    r_state;
  logic [3:0]    r_cnt;
  logic [AW-1:0] r_idx;
  logic          r_err;
  logic          r_rsp_valid;
  logic [31:0]   r_rsp_data;
  logic          r_rsp_err;
  logic [31:0]   r_mem [DEPTH_WORDS];
  logic w_accept, w_hs, w_read, w_load, w_unused;
  assign req_ready = !reset && (r_state == S_IDLE || (r_state == S_RESP && rsp_ready));
  assign w_accept  = req_valid && req_ready;
  assign w_hs      = r_rsp_valid && rsp_ready;
  // A WAIT cycle with the counter exhausted is the read cycle; with LATENCY=0 it is the only WAIT cycle.
  assign w_read    = r_state == S_WAIT && r_cnt == 4'd0;
  // DEPTH_WORDS is a power of two, so any set bit above the index field means out of range.
  assign w_load    = load_en && !(|load_addr[31:AW+2]);
  assign w_unused  = ^load_addr[1:0];
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign busy      = r_state != S_IDLE;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_idx       <= '0;
      r_err       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_state <= S_WAIT;
        r_cnt   <= LAT;
        r_idx   <= req_addr[AW+1:2];
        r_err   <= |req_addr[1:0] || |req_addr[31:AW+2];
      end else if (w_read)
        r_state <= S_RESP;
      else if (r_state == S_WAIT)
        r_cnt <= r_cnt - 4'd1;
      else if (w_hs)
        r_state <= S_IDLE;
      // A handshake always retires the response, even when a new request is accepted alongside it.
      if (w_read) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= r_err ? NOP : r_mem[r_idx];
        r_rsp_err   <= r_err;
      end else if (w_hs)
        r_rsp_valid <= 1'b0;
    end
  end
  always_ff @(posedge clk)
    if (w_load) r_mem[load_addr[AW+1:2]] <= load_data;
endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        reset, req_valid, rsp_ready, load_en;
  logic [31:0] req_addr, load_addr, load_data;
  logic        req_ready, rsp_valid, rsp_err, busy;
  logic [31:0] rsp_data;
  logic        z_req_valid, z_rsp_ready;
  logic [31:0] z_req_addr;
  logic        z_req_ready, z_rsp_valid, z_rsp_err, z_busy;
  logic [31:0] z_rsp_data;
  int n_checks = 0;
  int n_fail = 0;

  imem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .busy(busy));

  imem_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(z_req_valid), .req_ready(z_req_ready), .req_addr(z_req_addr),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_data(z_rsp_data), .rsp_err(z_rsp_err),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .busy(z_busy));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick;
    load_en = 1'b0;
  endtask

  // Drives one fetch with rsp_ready high; lat = edges from accept edge to rsp_valid seen (20 = timeout).
  task automatic do_fetch(input logic [31:0] a, output int lat, output logic [31:0] d, output logic e);
    int k;
    k = 0;
    req_valid = 1'b1; req_addr = a; rsp_ready = 1'b1;
    #1;
    while (!req_ready && k < 20) begin tick; k++; end
    tick;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin tick; lat++; end
    d = rsp_data; e = rsp_err;
    tick;
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 1'b0; req_addr = 32'd0; rsp_ready = 1'b0;
    load_en = 1'b0; load_addr = 32'd0; load_data = 32'd0;
    z_req_valid = 1'b0; z_req_addr = 32'd0; z_rsp_ready = 1'b0;
    load_word(32'h0000_0000, 32'h0050_0093);
    load_word(32'h0000_0004, 32'h1111_1111);
    load_word(32'h0000_0008, 32'h2222_2222);
    load_word(32'h0000_000C, 32'h3333_3333);
    load_word(32'h0000_0FFC, 32'h1234_5678);
    load_word(32'h0000_1000, 32'h0BAD_0BAD);
    req_valid = 1'b1; z_req_valid = 1'b1;
    #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_checks++; if (rsp_data !== 32'd0) begin n_fail++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
    n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    n_checks++; if (z_req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready_lat0: got %b want 0", z_req_ready); end
    req_valid = 1'b0; z_req_valid = 1'b0; reset = 1'b0;
    #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL idle_req_ready: got %b want 1", req_ready); end
    tick;
  endtask

  task automatic test_basic;
    int lat; logic [31:0] d; logic e;
    do_fetch(32'h0, lat, d, e);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL basic_latency: got %0d want 3", lat); end
    n_checks++; if (d !== 32'h0050_0093) begin n_fail++; $display("FAIL basic_data: got %h want 00500093", d); end
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b want 0", e); end
    n_checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got busy=%b valid=%b want 0 0", busy, rsp_valid); end
    n_checks++; if (rsp_data !== 32'h0050_0093) begin n_fail++; $display("FAIL basic_data_hold: got %h want 00500093", rsp_data); end
  endtask

  task automatic test_errors;
    logic [31:0] addrs [4] = '{32'h6, 32'h1000, 32'hFFC, 32'hFFFF_FFFC};
    logic [31:0] exp_d [4] = '{32'h13, 32'h13, 32'h1234_5678, 32'h13};
    logic        exp_e [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    int lat; logic [31:0] d; logic e;
    for (int i = 0; i < 4; i++) begin
      do_fetch(addrs[i], lat, d, e);
      n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL err_latency[%h]: got %0d want 3", addrs[i], lat); end
      n_checks++; if (d !== exp_d[i]) begin n_fail++; $display("FAIL err_data[%h]: got %h want %h", addrs[i], d, exp_d[i]); end
      n_checks++; if (e !== exp_e[i]) begin n_fail++; $display("FAIL err_flag[%h]: got %b want %b", addrs[i], e, exp_e[i]); end
    end
  endtask

  task automatic test_stall;
    int lat;
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h8;
    tick;
    req_addr = 32'h4;
    lat = 0;
    while (!rsp_valid && lat < 20) begin tick; lat++; end
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL stall_first_latency: got %0d want 3", lat); end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b want 1", i, rsp_valid); end
      n_checks++; if (rsp_data !== 32'h2222_2222) begin n_fail++; $display("FAIL stall_data[%0d]: got %h want 22222222", i, rsp_data); end
      n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL stall_req_ready[%0d]: got %b want 0", i, req_ready); end
      tick;
    end
    rsp_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready: got %b want 1", req_ready); end
    tick;
    req_valid = 1'b0;
    n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL stall_rehandshake: got valid=%b busy=%b want 0 1", rsp_valid, busy); end
    lat = 0;
    while (!rsp_valid && lat < 20) begin tick; lat++; end
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL stall_second_latency: got %0d want 3", lat); end
    n_checks++; if (rsp_data !== 32'h1111_1111) begin n_fail++; $display("FAIL stall_second_data: got %h want 11111111", rsp_data); end
    tick;
  endtask

  task automatic test_latency0;
    logic [31:0] exp_d [3] = '{32'h0050_0093, 32'h1111_1111, 32'h2222_2222};
    logic [31:0] got[$];
    int acc_edge[$];
    int rsp_edge[$];
    int idx;
    logic acc;
    idx = 0;
    z_rsp_ready = 1'b1; z_req_valid = 1'b1; z_req_addr = 32'h0;
    #1;
    for (int c = 0; c < 12; c++) begin
      if (z_rsp_valid) begin got.push_back(z_rsp_data); rsp_edge.push_back(c); end
      acc = z_req_valid && z_req_ready;
      tick;
      if (acc) begin
        acc_edge.push_back(c + 1);
        idx++;
        z_req_addr = 32'(idx * 4);
        if (idx == 3) z_req_valid = 1'b0;
      end
    end
    n_checks++; if (got.size() !== 3) begin n_fail++; $display("FAIL lat0_count: got %0d want 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size() && i < acc_edge.size(); i++) begin
      n_checks++; if (got[i] !== exp_d[i]) begin n_fail++; $display("FAIL lat0_data[%0d]: got %h want %h", i, got[i], exp_d[i]); end
      n_checks++; if (rsp_edge[i] !== acc_edge[i] + 1) begin n_fail++; $display("FAIL lat0_latency[%0d]: got edge %0d want %0d", i, rsp_edge[i], acc_edge[i] + 1); end
    end
    n_checks++; if (z_busy !== 1'b0 || z_rsp_err !== 1'b0) begin n_fail++; $display("FAIL lat0_idle: got busy=%b err=%b want 0 0", z_busy, z_rsp_err); end
  endtask

  task automatic test_load_hazard;
    int lat; logic [31:0] d; logic e;
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'hC;
    tick;
    req_valid = 1'b0;
    load_en = 1'b1; load_addr = 32'hC; load_data = 32'hDEAD_BEEF;
    tick;
    load_en = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin tick; lat++; end
    n_checks++; if (rsp_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL hazard_early_write: got %h want deadbeef", rsp_data); end
    tick;
    load_word(32'hC, 32'h3333_3333);
    req_valid = 1'b1; req_addr = 32'hC;
    tick;
    req_valid = 1'b0;
    tick;
    tick;
    load_en = 1'b1; load_addr = 32'hC; load_data = 32'hDEAD_BEEF;
    tick;
    load_en = 1'b0;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h3333_3333) begin n_fail++; $display("FAIL hazard_read_cycle_write: got valid=%b data=%h want 1 33333333", rsp_valid, rsp_data); end
    tick;
    do_fetch(32'hC, lat, d, e);
    n_checks++; if (d !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL hazard_write_landed: got %h want deadbeef", d); end
  endtask

  task automatic test_reset_mid;
    int lat; logic [31:0] d; logic e; logic seen;
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h4;
    tick;
    req_valid = 1'b0;
    tick;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_wait_busy: got %b want 1", busy); end
    reset = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0 || req_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_wait_reset: got busy=%b ready=%b want 0 0", busy, req_ready); end
    tick;
    reset = 1'b0;
    seen = 1'b0;
    repeat (6) begin tick; if (rsp_valid) seen = 1'b1; end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rmid_wait_stale: got valid seen=%b want 0", seen); end
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h8;
    tick;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin tick; lat++; end
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_resp_reached: got %b want 1", rsp_valid); end
    reset = 1'b1;
    #1;
    n_checks++; if (rsp_valid !== 1'b0 || rsp_data !== 32'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL rmid_resp_reset: got valid=%b data=%h busy=%b want 0 0 0", rsp_valid, rsp_data, busy); end
    tick;
    reset = 1'b0;
    seen = 1'b0;
    rsp_ready = 1'b1;
    repeat (6) begin tick; if (rsp_valid) seen = 1'b1; end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rmid_resp_stale: got valid seen=%b want 0", seen); end
    do_fetch(32'h4, lat, d, e);
    n_checks++; if (lat !== 3 || d !== 32'h1111_1111 || e !== 1'b0) begin n_fail++; $display("FAIL rmid_refetch: got lat=%0d data=%h err=%b want 3 11111111 0", lat, d, e); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_errors;
    test_stall;
    test_latency0;
    test_load_hazard;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
